score_to_seven_segment: RTL and testbench
=========================================

// Module: score_to_seven_segment
// PURPOSE
//  Multi-digit successor to the single-digit decimal decoder. Converts an unsigned binary score to
//  NUM_DIGITS active-low seven-segment patterns using a sequential double-dabble converter.
//  Sits between game-state logic (score counter) and the HEX display pins.
//  Out-of-range values show dashes on every digit. Each conversion has a fixed, known latency.
// PARAMETERS
//  NUM_DIGITS  4   number of decimal digits driven (1..8)
//  BIN_WIDTH   14  width of binary input; must satisfy 2^BIN_WIDTH-1 >= 10^NUM_DIGITS-1 (not checked)
// PORTS
//  clock        in   1               system clock, rising edge
//  reset_n      in   1               asynchronous, active-low reset
//  value        in   BIN_WIDTH       binary score; sampled only when load accepted
//  load         in   1               request conversion; accepted only when ready=1
//  ready        out  1               1 = IDLE, can accept load
//  done         out  1               one-cycle pulse: seg_out/overflow updated this cycle
//  overflow     out  1               1 = last accepted value > 10^NUM_DIGITS-1
//  seg_out      out  7*NUM_DIGITS    digit k at [7k+6:7k], k=0 least significant; bit order {g,f,e,d,c,b,a}, 0=lit
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, ready=1, done=0, overflow=0,
//   every digit = 7'b1000000 ("0"); internal shift/BCD registers cleared.
//  FSM: IDLE -(load)-> SHIFT -(BIN_WIDTH shifts done)-> ENCODE -> IDLE.
//   IDLE:   on load: capture value into shift reg, clear BCD reg, bit counter=0, ready=0.
//   SHIFT:  each cycle: add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1; counter++.
//           leave after exactly BIN_WIDTH cycles.
//   ENCODE: register seg_out, overflow; pulse done=1; return to IDLE (ready=1 next cycle).
//  Latency: load sampled at edge N -> done=1 and new seg_out visible after edge N+BIN_WIDTH+1.
//   Next load accepted at edge N+BIN_WIDTH+2 at the earliest.
//  BCD register is 4*NUM_DIGITS bits. Overflow = captured value > 10^NUM_DIGITS-1,
//   compared against full-width capture (not truncated BCD).
//  Overflow: every digit = 7'b0111111 (dash), overflow=1. Otherwise overflow=0, digits per table:
//   0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010
//   6:0000010 7:1111000 8:0000000 9:0010000 other nibble:0111111
//  load while ready=0: ignored; no queueing; value not resampled.
//  seg_out and overflow hold their last value between conversions. They never glitch mid-conversion.
//  reset_n low mid-conversion: abort immediately, all outputs to reset values; no done pulse.
//  value=0: all digits "0". Max legal value (9999 at defaults): all "9", overflow=0.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   In ENCODE, a zero digit above the most significant non-zero digit = 7'b1111111 (dark).
//   Digit 0 is never blanked, so value=0 shows a single "0". No effect on overflow dashes.
//   The reset pattern becomes a single "0" on digit 0 with all higher digits dark.
//  Not defined: all digits always shown, leading zeros included. Reset value as above.
// STRUCTURE
//  Shared package score_display_pkg:
//   SEG_* 7-bit constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK).
//   state encoding typedef/localparams (ST_IDLE, ST_SHIFT, ST_ENCODE).
//  Sub-module seven_seg_digit_encoder: combinational 4-bit nibble -> 7-bit pattern via the package
//   constants; instantiated NUM_DIGITS times in a generate loop. The top holds the FSM, the
//   double-dabble datapath, and the blanking/overflow muxing.
// TESTING
//  1 reset: hold reset_n=0, release -> seg_out all 7'b1000000, ready=1, done=0, overflow=0.
//  2 value=1234, load 1 cycle -> done after exactly 15 edges;
//    digits3..0 = 1111001,0100100,0110000,0011001; overflow=0.
//  3 value=10000 -> all digits 0111111, overflow=1. Then value=9999 -> all 0010000, overflow=0.
//  4 load held high during busy, with value changing to 5 mid-conversion -> result reflects the
//    first captured value only; exactly one done per accepted load.
//  5 reset_n pulsed low at SHIFT cycle 7 of value=8888 -> outputs return to reset values;
//    no done pulse; next load works normally.
//  6 LEADING_ZERO_BLANK_EN: value=42 -> digits3..0 = 1111111,1111111,0011001,0100100;
//    value=0 -> only digit0 lit "0".

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared seven-segment patterns (active-low {g,f,e,d,c,b,a}), converter state encoding and range helper.
package score_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_ENCODE = 2'd2;

  // Largest value representable on the given number of decimal digits (10^digits - 1).
  function automatic logic [63:0] max_display_value(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/seven_seg_digit_encoder.sv
// Combinational BCD nibble to active-low segment pattern; zero latency, no flow control.
// Non-decimal nibbles render as a dash.
module seven_seg_digit_encoder
  import score_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_to_seven_segment.sv
// Binary score to NUM_DIGITS seven-segment digits via sequential double-dabble; done BIN_WIDTH+1 edges after load.
// Loads are accepted only while ready=1 (no queueing); LEADING_ZERO_BLANK_EN darkens leading zero digits.
module score_to_seven_segment
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [BIN_WIDTH-1:0]    value,
  input  logic                    load,
  output logic                    ready,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0] MAX_VAL = max_display_value(NUM_DIGITS);

  function automatic logic [SEG_W-1:0] reset_pattern();
    logic [SEG_W-1:0] p;
`ifdef LEADING_ZERO_BLANK_EN
    p      = {NUM_DIGITS{SEG_BLANK}};
    p[6:0] = SEG_0;
`else
    p      = {NUM_DIGITS{SEG_0}};
`endif
    return p;
  endfunction

  localparam logic [SEG_W-1:0] SEG_RESET = reset_pattern();

  logic [1:0]           r_state;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]     r_bcd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_cap;
  logic                 r_done;
  logic                 r_ovf;
  logic [SEG_W-1:0]     r_seg;

  logic [BCD_W-1:0]     w_bcd_adj;
  logic [SEG_W-1:0]     w_dig;
  logic [SEG_W-1:0]     w_seg_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic                 w_lead_zero;
`endif

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) begin
        w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seven_seg_digit_encoder u_enc (
      .i_nibble (r_bcd[4*g +: 4]),
      .o_seg    (w_dig[7*g +: 7])
    );
  end

  // Overflow is judged on the full-width capture, so the truncated BCD is never shown.
  always_comb begin
    w_seg_next = w_dig;
`ifdef LEADING_ZERO_BLANK_EN
    w_lead_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_lead_zero = w_lead_zero && (r_bcd[4*k +: 4] == 4'd0);
      if (w_lead_zero) begin
        w_seg_next[7*k +: 7] = SEG_BLANK;
      end
    end
`endif
    if (r_ovf_cap) begin
      w_seg_next = {NUM_DIGITS{SEG_DASH}};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_seg     <= SEG_RESET;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_bin     <= value;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf_cap <= (64'(value) > MAX_VAL);
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[BIN_WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_WIDTH - 1)) begin
            r_state <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          r_seg   <= w_seg_next;
          r_ovf   <= r_ovf_cap;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready    = (r_state == ST_IDLE);
  assign done     = r_done;
  assign overflow = r_ovf;
  assign seg_out  = r_seg;

endmodule

// File: tb/tb_score_to_seven_segment.sv
// Table-driven and scoreboard-checked bench for score_to_seven_segment at default parameters.
module tb_score_to_seven_segment;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int SW = 7 * ND;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000, DASH = 7'b0111111, BLK = 7'b1111111;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [SW-1:0] RESET_SEG = {BLK, BLK, BLK, D0};
`else
  localparam logic [SW-1:0] RESET_SEG = {D0, D0, D0, D0};
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          load = 1'b0;
  logic [BW-1:0] value = '0;
  logic          ready, done, overflow;
  logic [SW-1:0] seg_out;

  always #5 clock = ~clock;

  score_to_seven_segment #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .ready    (ready),
    .done     (done),
    .overflow (overflow),
    .seg_out  (seg_out)
  );

  typedef struct {
    logic [BW-1:0] v;
    logic [SW-1:0] seg;
    logic          ovf;
  } vec_t;

  typedef struct {
    logic [SW-1:0] seg;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t tbl[7];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return D0;  1: return D1;  2: return D2;  3: return D3;  4: return D4;
      5: return D5;  6: return D6;  7: return D7;  8: return D8;  default: return D9;
    endcase
  endfunction

  function automatic logic [SW-1:0] model_seg(input int v);
    logic [SW-1:0] r;
    int            pw;
    int            d;
    logic          lead;
    if (v > 9999) return {ND{DASH}};
    lead = 1'b1;
    pw = 1000;
    for (int k = ND - 1; k >= 0; k--) begin
      d = (v / pw) % 10;
      pw = pw / 10;
      if (d != 0) lead = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      r[7*k +: 7] = (lead && k != 0) ? BLK : digit_seg(d);
`else
      r[7*k +: 7] = digit_seg(d);
`endif
    end
    return r;
  endfunction

  always @(negedge clock) begin
    if (reset_n && done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_seg", seg_out, mon_e.seg);
        check("sb_overflow", overflow, mon_e.ovf);
      end
    end
  end

  task automatic wait_ready();
    int c;
    c = 0;
    while (!ready && c < 50) begin
      @(negedge clock);
      c++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic run_conv(input logic [BW-1:0] v, input logic [SW-1:0] s, input logic o);
    int            cnt;
    logic          held;
    logic [SW-1:0] seg0;
    logic          ovf0;
    wait_ready();
    @(negedge clock);
    value = v;
    load  = 1'b1;
    sb_q.push_back('{seg: s, ovf: o});
    seg0 = seg_out;
    ovf0 = overflow;
    @(posedge clock);
    #1;
    load = 1'b0;
    check("busy_after_load", ready, 0);
    cnt  = 0;
    held = 1'b1;
    while (cnt < 40) begin
      @(posedge clock);
      cnt++;
      #1;
      if (done) break;
      if (seg_out !== seg0 || overflow !== ovf0) held = 1'b0;
    end
    check("latency", cnt, BW + 1);
    check("hold_mid_conversion", held, 1);
    check("ready_at_done", ready, 1);
    @(negedge clock);
    #1;
  endtask

  initial begin
    int d0;
    int c;
    int v;

    tbl[0] = '{v: 14'd1234, seg: {D1, D2, D3, D4}, ovf: 1'b0};
    tbl[1] = '{v: 14'd10000, seg: {ND{DASH}}, ovf: 1'b1};
    tbl[2] = '{v: 14'd9999, seg: {ND{D9}}, ovf: 1'b0};
    tbl[3] = '{v: 14'd16383, seg: {ND{DASH}}, ovf: 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
    tbl[4] = '{v: 14'd0, seg: {BLK, BLK, BLK, D0}, ovf: 1'b0};
    tbl[5] = '{v: 14'd42, seg: {BLK, BLK, D4, D2}, ovf: 1'b0};
    tbl[6] = '{v: 14'd1005, seg: {D1, D0, D0, D5}, ovf: 1'b0};
`else
    tbl[4] = '{v: 14'd0, seg: {D0, D0, D0, D0}, ovf: 1'b0};
    tbl[5] = '{v: 14'd42, seg: {D0, D0, D4, D2}, ovf: 1'b0};
    tbl[6] = '{v: 14'd1005, seg: {D1, D0, D0, D5}, ovf: 1'b0};
`endif

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_seg", seg_out, RESET_SEG);
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_overflow", overflow, 0);

    for (int i = 0; i < 7; i++) begin
      run_conv(tbl[i].v, tbl[i].seg, tbl[i].ovf);
    end

    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 12000));
      run_conv(BW'(v), model_seg(v), v > 9999);
    end

    // Load held high through a busy period while value changes underneath.
    wait_ready();
    d0 = n_done;
    @(negedge clock);
    value = 14'd777;
    load  = 1'b1;
    sb_q.push_back('{seg: model_seg(777), ovf: 1'b0});
    c = 0;
    while (!done && c < 40) begin
      @(negedge clock);
      c++;
      if (c == 3) value = 14'd5;
    end
    load = 1'b0;
    check("busy_done_seen", done, 1);
    repeat (20) @(negedge clock);
    check("busy_single_done", n_done - d0, 1);
    check("busy_queue_empty", sb_q.size(), 0);

    run_conv(14'd10000, {ND{DASH}}, 1'b1);

    // Reset pulse in the middle of converting 8888.
    wait_ready();
    d0 = n_done;
    @(negedge clock);
    value = 14'd8888;
    load  = 1'b1;
    @(posedge clock);
    #1;
    load = 1'b0;
    repeat (7) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_seg", seg_out, RESET_SEG);
    check("abort_overflow", overflow, 0);
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (25) @(negedge clock);
    check("abort_no_done", n_done - d0, 0);
    check("abort_seg_hold", seg_out, RESET_SEG);
    run_conv(14'd8888, {ND{D8}}, 1'b0);

    repeat (3) @(negedge clock);
    check("final_queue_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
